// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: word width,
// RV32I load/store funct3 codes, FSM state encoding and request legality.
package dmem_lsu_pkg;

  localparam int WORD_LEN = 32;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_MERGE = 2'b10
  } lsu_state_e;

  // A request is rejected for an unknown funct3 or an address not aligned
  // to its access size; rejected requests never touch memory.
  function automatic logic req_is_err(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] lo);
    logic err;
    err = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB:   err = 1'b0;
        F3_SH:   err = lo[0];
        F3_SW:   err = (lo != 2'b00);
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: err = 1'b0;
        F3_LH, F3_LHU: err = lo[0];
        F3_LW:         err = (lo != 2'b00);
        default:       err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/dmem_lsu_byte_lane.sv
// Combinational lane logic: extracts a byte/half/word from a memory word for
// loads (with sign or zero extension) and merges store data into a word for
// sub-word stores. Lanes are little-endian.
module dmem_lsu_byte_lane
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic [1:0]          lane,
  input  logic [WORD_LEN-1:0] word,
  input  logic [WORD_LEN-1:0] wdata,
  output logic [WORD_LEN-1:0] load_data,
  output logic [WORD_LEN-1:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and half from the memory word
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (lane)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (lane[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Right-align and extend the selected lane for the load result
  always_comb begin
    load_data = 32'h0000_0000;
    case (funct3)
      F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
      F3_LH:   load_data = {{16{half_s[15]}}, half_s};
      F3_LW:   load_data = word;
      F3_LBU:  load_data = {24'h00_0000, byte_s};
      F3_LHU:  load_data = {16'h0000, half_s};
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Overlay store data onto the old word, leaving other lanes intact
  always_comb begin
    merged = word;
    case (funct3)
      F3_SB: begin
        case (lane)
          2'b00:   merged = {word[31:8], wdata[7:0]};
          2'b01:   merged = {word[31:16], wdata[7:0], word[7:0]};
          2'b10:   merged = {word[31:24], wdata[7:0], word[15:0]};
          2'b11:   merged = {wdata[7:0], word[23:0]};
          default: merged = word;
        endcase
      end
      F3_SH: begin
        if (lane[1]) begin
          merged = {wdata[15:0], word[15:0]};
        end else begin
          merged = {word[31:16], wdata[15:0]};
        end
      end
      F3_SW:   merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-indexed, 1-cycle-latency data memory.
// Aligned word stores complete in the accept cycle; loads take a LOAD cycle
// to capture read data; byte/half stores read the word, then write the
// merged word from MERGE. Illegal or misaligned requests are answered with
// an error response and no memory access.
module dmem_lsu
  import dmem_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e          state_r;
  lsu_state_e          state_nxt_s;

  logic [WORD_LEN-1:0] addr_r;
  logic [2:0]          funct3_r;
  logic [WORD_LEN-1:0] wdata_r;

  logic                rsp_valid_r;
  logic                rsp_err_r;
  logic [WORD_LEN-1:0] rsp_rdata_r;
  logic                rsp_valid_nxt_s;
  logic                rsp_err_nxt_s;
  logic [WORD_LEN-1:0] rsp_rdata_nxt_s;

  logic                accept_s;
  logic                err_s;
  logic                latch_s;
  logic                wen_s;
  logic [WORD_LEN-1:0] wdata_s;
  logic [WORD_LEN-1:0] load_data_s;
  logic [WORD_LEN-1:0] merged_s;

  assign accept_s = req_valid && (state_r == ST_IDLE);
  assign err_s    = req_is_err(req_we, req_funct3, req_addr[1:0]);

  // Lane logic works on the latched request and the word read back from memory
  dmem_lsu_byte_lane u_lane (
    .funct3    (funct3_r),
    .lane      (addr_r[1:0]),
    .word      (mem_rdata),
    .wdata     (wdata_r),
    .load_data (load_data_s),
    .merged    (merged_s)
  );

  // Next-state, memory port drive and next response value
  always_comb begin
    state_nxt_s     = state_r;
    req_ready       = 1'b0;
    mem_addr        = {req_addr[31:2], 2'b00};
    wen_s           = 1'b0;
    wdata_s         = 32'h0000_0000;
    latch_s         = 1'b0;
    rsp_valid_nxt_s = 1'b0;
    rsp_err_nxt_s   = 1'b0;
    rsp_rdata_nxt_s = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (accept_s) begin
          if (err_s) begin
            rsp_valid_nxt_s = 1'b1;
            rsp_err_nxt_s   = 1'b1;
            state_nxt_s     = ST_IDLE;
          end else if (req_we && (req_funct3 == F3_SW)) begin
            wen_s           = 1'b1;
            wdata_s         = req_wdata;
            rsp_valid_nxt_s = 1'b1;
            state_nxt_s     = ST_IDLE;
          end else if (req_we) begin
            latch_s     = 1'b1;
            state_nxt_s = ST_MERGE;
          end else begin
            latch_s     = 1'b1;
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        mem_addr        = {addr_r[31:2], 2'b00};
        rsp_valid_nxt_s = 1'b1;
        rsp_rdata_nxt_s = load_data_s;
        state_nxt_s     = ST_IDLE;
      end
      ST_MERGE: begin
        mem_addr        = {addr_r[31:2], 2'b00};
        wen_s           = 1'b1;
        wdata_s         = merged_s;
        rsp_valid_nxt_s = 1'b1;
        state_nxt_s     = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Write enable is killed during reset so an in-flight merge cannot land
  assign mem_wen   = wen_s & rst_n;
  assign mem_wdata = wdata_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Hold the accepted request for the LOAD / MERGE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r   <= 32'h0000_0000;
      funct3_r <= 3'b000;
      wdata_r  <= 32'h0000_0000;
    end else if (latch_s) begin
      addr_r   <= req_addr;
      funct3_r <= req_funct3;
      wdata_r  <= req_wdata;
    end else begin
      addr_r   <= addr_r;
      funct3_r <= funct3_r;
      wdata_r  <= wdata_r;
    end
  end

  // Registered one-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
    end else begin
      rsp_valid_r <= rsp_valid_nxt_s;
      rsp_err_r   <= rsp_err_nxt_s;
      rsp_rdata_r <= rsp_rdata_nxt_s;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a word-indexed synchronous-read memory.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem [0:1023];

  int passed = 0;
  int total  = 0;

  // observations of the last request
  int          rsp_cyc;
  int          rsp_cnt;
  logic [31:0] rsp_data;
  logic        rsp_e;
  logic [3:0]  wen_mask;
  logic        ready0;

  always #5 clk = ~clk;

  // Synchronous-read data memory, 1-cycle latency
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr[11:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[11:2]];
  end

  dmem_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Issue one request (accept at the next posedge) and watch cycles 0..3
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    #1;
    wen_mask = 4'b0000; rsp_cyc = -1; rsp_cnt = 0; rsp_data = 32'h0; rsp_e = 1'b0;
    wen_mask[0] = mem_wen;
    ready0 = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    for (int c = 1; c < 4; c++) begin
      wen_mask[c] = mem_wen;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_cyc < 0) begin
          rsp_cyc = c; rsp_data = rsp_rdata; rsp_e = rsp_err;
        end
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_reset();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h55;
    #3;
    total++; if (mem_wen !== 1'b0) $display("FAIL rst_wen: got %b want 0", mem_wen); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", rsp_valid); else passed++;
    total++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rsp_rdata); else passed++;
    total++; if (rsp_err !== 1'b0) $display("FAIL rst_err: got %b want 0", rsp_err); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", req_ready); else passed++;
    repeat (2) @(posedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sw_lw();
    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    total++; if (ready0 !== 1'b1) $display("FAIL sw_ready: got %b want 1", ready0); else passed++;
    total++; if (wen_mask !== 4'b0001) $display("FAIL sw_wen: got %b want 0001", wen_mask); else passed++;
    total++; if (rsp_cyc != 1 || rsp_cnt != 1) $display("FAIL sw_rsp_cyc: got %0d/%0d want 1/1", rsp_cyc, rsp_cnt); else passed++;
    total++; if (rsp_data !== 32'h0 || rsp_e !== 1'b0) $display("FAIL sw_rsp: got %h/%b want 0/0", rsp_data, rsp_e); else passed++;
    total++; if (mem[32'h40] !== 32'hDEADBEEF) $display("FAIL sw_mem: got %h want deadbeef", mem[32'h40]); else passed++;
    do_req(1'b0, 3'b010, 32'h100, 32'h0);
    total++; if (wen_mask !== 4'b0000) $display("FAIL lw_wen: got %b want 0000", wen_mask); else passed++;
    total++; if (rsp_cyc != 2 || rsp_cnt != 1) $display("FAIL lw_rsp_cyc: got %0d/%0d want 2/1", rsp_cyc, rsp_cnt); else passed++;
    total++; if (rsp_data !== 32'hDEADBEEF) $display("FAIL lw_data: got %h want deadbeef", rsp_data); else passed++;
    total++; if (rsp_e !== 1'b0) $display("FAIL lw_err: got %b want 0", rsp_e); else passed++;
  endtask

  task automatic test_sub_word();
    logic [2:0]  lf3 [4];
    logic [31:0] laddr [4];
    logic [31:0] lexp [4];
    do_req(1'b1, 3'b010, 32'h200, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h201, 32'h000000AA);
    total++; if (wen_mask !== 4'b0010) $display("FAIL sb_wen: got %b want 0010", wen_mask); else passed++;
    total++; if (rsp_cyc != 2 || rsp_cnt != 1) $display("FAIL sb_rsp_cyc: got %0d/%0d want 2/1", rsp_cyc, rsp_cnt); else passed++;
    total++; if (rsp_data !== 32'h0 || rsp_e !== 1'b0) $display("FAIL sb_rsp: got %h/%b want 0/0", rsp_data, rsp_e); else passed++;
    total++; if (mem[32'h80] !== 32'h1122AA44) $display("FAIL sb_mem: got %h want 1122aa44", mem[32'h80]); else passed++;
    do_req(1'b0, 3'b000, 32'h201, 32'h0);
    total++; if (rsp_data !== 32'hFFFFFFAA || rsp_cyc != 2) $display("FAIL lb_201: got %h@%0d want ffffffaa@2", rsp_data, rsp_cyc); else passed++;
    do_req(1'b0, 3'b100, 32'h201, 32'h0);
    total++; if (rsp_data !== 32'h000000AA) $display("FAIL lbu_201: got %h want 000000aa", rsp_data); else passed++;
    do_req(1'b1, 3'b001, 32'h202, 32'h5A5A8001);
    total++; if (wen_mask !== 4'b0010) $display("FAIL sh_wen: got %b want 0010", wen_mask); else passed++;
    total++; if (mem[32'h80] !== 32'h8001AA44) $display("FAIL sh_mem: got %h want 8001aa44", mem[32'h80]); else passed++;
    lf3   = '{3'b001, 3'b101, 3'b000, 3'b100};
    laddr = '{32'h202, 32'h202, 32'h200, 32'h203};
    lexp  = '{32'hFFFF8001, 32'h00008001, 32'h00000044, 32'h00000080};
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, lf3[i], laddr[i], 32'h0);
      total++;
      if (rsp_data !== lexp[i] || rsp_e !== 1'b0)
        $display("FAIL subload_%0d: got %h/%b want %h/0", i, rsp_data, rsp_e, lexp[i]);
      else passed++;
    end
  endtask

  task automatic test_errors();
    logic        ewe [4];
    logic [2:0]  ef3 [4];
    logic [31:0] eaddr [4];
    ewe   = '{1'b0, 1'b1, 1'b0, 1'b1};
    ef3   = '{3'b010, 3'b001, 3'b011, 3'b011};
    eaddr = '{32'h103, 32'h101, 32'h100, 32'h100};
    for (int i = 0; i < 4; i++) begin
      do_req(ewe[i], ef3[i], eaddr[i], 32'h0000FFFF);
      total++;
      if (wen_mask !== 4'b0000 || rsp_cyc != 1 || rsp_cnt != 1 || rsp_e !== 1'b1 || rsp_data !== 32'h0)
        $display("FAIL err_%0d: got wen=%b cyc=%0d cnt=%0d err=%b data=%h want 0000/1/1/1/0",
                 i, wen_mask, rsp_cyc, rsp_cnt, rsp_e, rsp_data);
      else passed++;
    end
    total++; if (mem[32'h40] !== 32'hDEADBEEF) $display("FAIL err_mem: got %h want deadbeef", mem[32'h40]); else passed++;
  endtask

  task automatic test_back_to_back();
    logic       rdy_ok;
    int         wen_cnt;
    logic [5:0] vmask;
    rdy_ok = 1'b1; wen_cnt = 0; vmask = 6'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'(i * 4); req_wdata = 32'hA5000000 + 32'(i);
      end else begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      end
      #1;
      if (i < 4) begin
        rdy_ok = rdy_ok & req_ready;
        if (mem_wen) wen_cnt++;
      end
      vmask[i] = rsp_valid;
    end
    total++; if (rdy_ok !== 1'b1) $display("FAIL b2b_ready: got %b want 1", rdy_ok); else passed++;
    total++; if (wen_cnt != 4) $display("FAIL b2b_wen: got %0d want 4", wen_cnt); else passed++;
    total++; if (vmask !== 6'b011110) $display("FAIL b2b_rsp: got %b want 011110", vmask); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[i] !== 32'hA5000000 + 32'(i)) $display("FAIL b2b_mem_%0d: got %h want %h", i, mem[i], 32'hA5000000 + 32'(i));
      else passed++;
    end
    do_req(1'b0, 3'b010, 32'hC, 32'h0);
    total++; if (rsp_data !== 32'hA5000003) $display("FAIL b2b_readback: got %h want a5000003", rsp_data); else passed++;
  endtask

  task automatic test_reset_mid_merge();
    do_req(1'b1, 3'b010, 32'h300, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h301; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    total++; if (mem_wen !== 1'b1) $display("FAIL merge_wen: got %b want 1", mem_wen); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (mem_wen !== 1'b0) $display("FAIL rmid_wen: got %b want 0", mem_wen); else passed++;
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      $display("FAIL rmid_rsp: got %b/%h/%b want 0/0/0", rsp_valid, rsp_rdata, rsp_err); else passed++;
    total++; if (req_ready !== 1'b1) $display("FAIL rmid_ready: got %b want 1", req_ready); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rmid_norsp: got %b want 0", rsp_valid); else passed++;
    total++; if (mem[32'hC0] !== 32'hCAFEF00D) $display("FAIL rmid_mem: got %h want cafef00d", mem[32'hC0]); else passed++;
    do_req(1'b0, 3'b010, 32'h300, 32'h0);
    total++; if (ready0 !== 1'b1 || rsp_cyc != 2 || rsp_data !== 32'hCAFEF00D)
      $display("FAIL rmid_lw: got rdy=%b cyc=%0d data=%h want 1/2/cafef00d", ready0, rsp_cyc, rsp_data); else passed++;
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_sub_word();
    test_errors();
    test_back_to_back();
    test_reset_mid_merge();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1, "timeout");
  end

endmodule
